dw2_13_gen: RTL and testbench

DW2_13_GEN -- requirements
Module: dw2_13_gen

---
 rtl/dw2_13_gen_if.sv | 20 ++
 rtl/dw2_13_gen.sv | 97 +++++++++
 tb/tb_dw2_13_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dw2_13_gen_if.sv
// Handshake/data bundle between the weight-update controller and the
// delta-weight generator.
interface dw2_13_gen_if;
  logic               start;
  logic signed [15:0] delta2_1;
  logic signed [15:0] a1_3;
  logic signed [15:0] dw2_13;
  logic               select_update;
  logic               busy;

  modport master (
    output start, delta2_1, a1_3,
    input  dw2_13, select_update, busy
  );

  modport slave (
    input  start, delta2_1, a1_3,
    output dw2_13, select_update, busy
  );
endinterface

// File: rtl/dw2_13_gen.sv
// Delta-weight generator: dw2_13 = -(LR * (delta2_1 * a1_3)) in Q6.10, four-state FSM.
// Define DW_SAT_EN to saturate the 32-to-16-bit reductions instead of wrapping.
module dw2_13_gen #(
  parameter logic signed [15:0] LR = 16'sd205
) (
  input logic        clk,
  input logic        reset,
  dw2_13_gen_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMul1, StMul2, StOut} state_e;

  state_e             state_q;
  logic signed [15:0] delta_q;
  logic signed [15:0] act_q;
  logic signed [15:0] grad_q;
  logic signed [15:0] dw_q;
  logic               update_q;
  logic               busy_q;

  logic signed [31:0] prod_grad;
  logic signed [31:0] prod_step;
  logic signed [15:0] grad_d;
  logic signed [15:0] step_d;
  logic signed [15:0] dw_d;

  function automatic logic signed [15:0] reduce16(input logic signed [31:0] v);
`ifdef DW_SAT_EN
    if (v > 32'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
`else
    return v[15:0];
`endif
  endfunction

  // Arithmetic shift gives floor rounding for negative products.
  always_comb begin
    prod_grad = 32'(delta_q) * 32'(act_q);
    prod_step = 32'(LR) * 32'(grad_q);
    grad_d    = reduce16(prod_grad >>> 10);
    step_d    = reduce16(prod_step >>> 10);
    dw_d      = (step_d == 16'sh8000) ? 16'sh7FFF : -step_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      delta_q  <= '0;
      act_q    <= '0;
      grad_q   <= '0;
      dw_q     <= '0;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          update_q <= 1'b0;
          if (bus.start) begin
            delta_q <= bus.delta2_1;
            act_q   <= bus.a1_3;
            state_q <= StMul1;
            busy_q  <= 1'b1;
          end
        end
        StMul1: begin
          grad_q  <= grad_d;
          state_q <= StMul2;
        end
        StMul2: begin
          dw_q     <= dw_d;
          update_q <= 1'b1;
          state_q  <= StOut;
        end
        StOut: begin
          update_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= StIdle;
        end
        default: begin
          state_q  <= StIdle;
          update_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dw2_13        = dw_q;
  assign bus.select_update = update_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dw2_13_gen.sv
// Self-checking bench for dw2_13_gen: directed vector table, corner sequences and
// randomized transactions against an arithmetic reference model.
module tb_dw2_13_gen;

  localparam int LR = 205;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  dw2_13_gen_if bus_if ();

  dw2_13_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    int d;
    int a;
    int exp_dw;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint floor_div1024(input longint v);
    longint q;
    q = v / 1024;
    if ((v % 1024 != 0) && (v < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int to16(input longint v);
`ifdef DW_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    longint r;
    r = v % 65536;
    if (r < 0) r = r + 65536;
    if (r >= 32768) r = r - 65536;
    return int'(r);
`endif
  endfunction

  function automatic int model_dw(input int d, input int a);
    int g;
    int s;
    g = to16(floor_div1024(longint'(d) * longint'(a)));
    s = to16(floor_div1024(longint'(LR) * longint'(g)));
    return (s == -32768) ? 32767 : -s;
  endfunction

  function automatic int s16(input logic signed [15:0] v);
    return int'(v);
  endfunction

  // One start pulse; cycles N+1..N+3 optionally carry ignored start/operand noise.
  task automatic run_txn(input string name, input int d, input int a, input int exp_dw,
                         input bit noise);
    int prev_dw;
    bus_if.start    = 1'b1;
    bus_if.delta2_1 = 16'(d);
    bus_if.a1_3     = 16'(a);
    step();
    for (int c = 1; c <= 2; c++) begin
      check({name, ".pre_strobe"}, int'(bus_if.select_update), 0);
      check({name, ".busy"}, int'(bus_if.busy), 1);
      bus_if.start    = noise ? 1'($urandom) : 1'b0;
      bus_if.delta2_1 = 16'($urandom);
      bus_if.a1_3     = 16'($urandom);
      step();
    end
    check({name, ".strobe"}, int'(bus_if.select_update), 1);
    check({name, ".dw"}, s16(bus_if.dw2_13), exp_dw);
    prev_dw = s16(bus_if.dw2_13);
    bus_if.start = noise ? 1'($urandom) : 1'b0;
    step();
    bus_if.start = 1'b0;
    check({name, ".post_strobe"}, int'(bus_if.select_update), 0);
    check({name, ".post_busy"}, int'(bus_if.busy), 0);
    check({name, ".hold"}, s16(bus_if.dw2_13), prev_dw);
  endtask

  initial begin
    vec_t vecs[$];
    int   strobe_off[$];
    int   strobe_dw[$];
    int   cap_d[2];
    int   cap_a[2];
    int   d;
    int   a;

    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.delta2_1 = '0;
    bus_if.a1_3     = '0;

    vecs.push_back('{1024, 512, -102});
    vecs.push_back('{-1024, 512, 103});
`ifdef DW_SAT_EN
    vecs.push_back('{32767, 32767, -6559});
    vecs.push_back('{-32768, -32768, -6559});
    vecs.push_back('{-32768, 32767, 6560});
`else
    // Low 16 bits of 1048512 are -64, giving floor(-12.8) = -13.
    vecs.push_back('{32767, 32767, 13});
    vecs.push_back('{-32768, -32768, 0});
    vecs.push_back('{-32768, 32767, -6});
`endif
    vecs.push_back('{0, 1234, 0});
    vecs.push_back('{2048, -1024, 410});

    step();
    step();
    reset = 1'b0;
    check("reset.dw", s16(bus_if.dw2_13), 0);
    check("reset.strobe", int'(bus_if.select_update), 0);
    check("reset.busy", int'(bus_if.busy), 0);
    step();
    check("idle.no_start_busy", int'(bus_if.busy), 0);

    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].a, vecs[i].exp_dw, 1'b0);

    // start held for 8 cycles with changing operands.
    for (int k = 0; k < 11; k++) begin
      bus_if.start = (k < 8);
      d = int'($signed(16'($urandom)));
      a = int'($signed(16'($urandom)));
      bus_if.delta2_1 = 16'(d);
      bus_if.a1_3     = 16'(a);
      if (k == 0) begin cap_d[0] = d; cap_a[0] = a; end
      if (k == 4) begin cap_d[1] = d; cap_a[1] = a; end
      step();
      if (bus_if.select_update) begin
        strobe_off.push_back(k + 1);
        strobe_dw.push_back(s16(bus_if.dw2_13));
      end
    end
    bus_if.start = 1'b0;
    check("hold8.count", strobe_off.size(), 2);
    if (strobe_off.size() == 2) begin
      check("hold8.off0", strobe_off[0], 3);
      check("hold8.off1", strobe_off[1], 7);
      check("hold8.dw0", strobe_dw[0], model_dw(cap_d[0], cap_a[0]));
      check("hold8.dw1", strobe_dw[1], model_dw(cap_d[1], cap_a[1]));
    end

    // Reset during MUL2 aborts the computation.
    bus_if.start    = 1'b1;
    bus_if.delta2_1 = 16'sd1024;
    bus_if.a1_3     = 16'sd512;
    step();
    bus_if.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort.dw", s16(bus_if.dw2_13), 0);
    check("abort.busy", int'(bus_if.busy), 0);
    check("abort.strobe", int'(bus_if.select_update), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort.no_strobe", int'(bus_if.select_update), 0);
    end
    run_txn("abort.fresh", -1024, 512, 103, 1'b0);

    // Reset wins over start on the same edge.
    reset        = 1'b1;
    bus_if.start = 1'b1;
    step();
    reset        = 1'b0;
    bus_if.start = 1'b0;
    check("prio.busy", int'(bus_if.busy), 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("prio.no_strobe", int'(bus_if.select_update), 0);
    end

    for (int t = 0; t < 60; t++) begin
      d = int'($signed(16'($urandom)));
      a = (t % 4 == 0) ? int'($signed(16'($urandom_range(0, 2047)))) :
                         int'($signed(16'($urandom)));
      run_txn($sformatf("rand%0d", t), d, a, model_dw(d, a), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
